// File: rtl/spi_responder_if.sv
// rtl/spi_responder_if.sv - host-side FIFO/status bus of the SPI responder
interface spi_responder_if;
    logic [7:0] tx_din;
    logic       tx_wr;
    logic       tx_full;
    logic       tx_empty;
    logic [7:0] rx_dout;
    logic       rx_rd;
    logic       rx_data_avail;
    logic       rx_overflow;
    logic       ovf_clr;
    logic       busy;

    modport master (
        output tx_din, tx_wr, rx_rd, ovf_clr,
        input  tx_full, tx_empty, rx_dout, rx_data_avail, rx_overflow, busy
    );

    modport slave (
        input  tx_din, tx_wr, rx_rd, ovf_clr,
        output tx_full, tx_empty, rx_dout, rx_data_avail, rx_overflow, busy
    );
endinterface

// File: rtl/spi_responder.sv
// rtl/spi_responder.sv - SPI mode-0 slave endpoint with TX/RX byte FIFOs
module spi_responder_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       Rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0] mem [DEPTH];
    logic [AW:0] wptr, rptr;
    logic do_pop, do_push;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    // Pop is evaluated first, so a full FIFO still accepts a push in a popping cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? 8'h00 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (Rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_pop)
                rptr <= rptr + {{AW{1'b0}}, 1'b1};
            if (do_push)
                wptr <= wptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wptr[AW-1:0]] <= din;
    end
endmodule

module spi_responder #(
    parameter int         FIFO_DEPTH  = 8,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic             spi_sck,
    input  logic             spi_cs,
    input  logic             spi_mosi,
    output logic             spi_miso,
    output logic             spi_miso_oe,
    spi_responder_if.slave   host
);
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic sck_s, cs_s, mosi_s, sck_prev, cs_prev;
    logic sck_rise, sck_fall, cs_fall, cs_rise;

    logic [6:0] shreg_tx;
    logic [6:0] shreg_rx;
    logic [3:0] bit_cnt;
    logic       tx_pop, rx_push;
    logic [7:0] tx_head, load_byte, rx_byte;
    logic       tx_full, tx_empty, rx_full, rx_empty, ovf_set;

    // cs synchronizer resets to "asserted" so a cs held low across reset
    // release never produces a falling edge and cannot start a frame.
    always_ff @(posedge clk) begin
        if (Rst) begin
            sck_sync  <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sck_prev  <= 1'b0;
            cs_prev   <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sck_prev  <= sck_s;
            cs_prev   <= cs_s;
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s && !sck_prev;
    assign sck_fall = !sck_s && sck_prev;
    assign cs_fall  = !cs_s && cs_prev;
    assign cs_rise  = cs_s && !cs_prev;

    assign load_byte = tx_empty ? IDLE_BYTE : tx_head;
    assign rx_byte   = {shreg_rx, mosi_s};

    always_ff @(posedge clk) begin
        if (Rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        tx_pop     = 1'b0;
        rx_push    = 1'b0;
        if (cs_rise) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (cs_fall)
                        state_next = LOAD;
                end
                LOAD: begin
                    tx_pop     = !tx_empty;
                    state_next = SHIFT;
                end
                SHIFT: begin
                    if (sck_rise && bit_cnt == 4'd7)
                        rx_push = 1'b1;
                    if (sck_fall && bit_cnt == 4'd8)
                        state_next = LOAD;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // A push refused because the RX FIFO is full (and not popping) is a drop.
    assign ovf_set = rx_push && rx_full && !(host.rx_rd && !rx_empty);

    always_ff @(posedge clk) begin
        if (Rst) begin
            shreg_tx         <= '0;
            shreg_rx         <= '0;
            bit_cnt          <= '0;
            spi_miso         <= 1'b1;
            host.rx_overflow <= 1'b0;
        end else begin
            if (cs_rise) begin
                spi_miso <= 1'b1;
            end else if (state == LOAD) begin
                shreg_tx <= load_byte[6:0];
                bit_cnt  <= '0;
                spi_miso <= load_byte[7];
            end else if (state == SHIFT) begin
                if (sck_rise) begin
                    shreg_rx <= rx_byte[6:0];
                    bit_cnt  <= bit_cnt + 4'd1;
                end
                if (sck_fall && bit_cnt != 4'd0 && bit_cnt != 4'd8) begin
                    spi_miso <= shreg_tx[6];
                    shreg_tx <= {shreg_tx[5:0], 1'b0};
                end
            end
            if (ovf_set)
                host.rx_overflow <= 1'b1;
            else if (host.ovf_clr)
                host.rx_overflow <= 1'b0;
        end
    end

    assign spi_miso_oe = (state != IDLE);
    assign host.busy   = (state != IDLE);

    spi_responder_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .Rst   (Rst),
        .push  (host.tx_wr),
        .din   (host.tx_din),
        .pop   (tx_pop),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    spi_responder_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .Rst   (Rst),
        .push  (rx_push),
        .din   (rx_byte),
        .pop   (host.rx_rd),
        .dout  (host.rx_dout),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign host.tx_full       = tx_full;
    assign host.tx_empty      = tx_empty;
    assign host.rx_data_avail = !rx_empty;
endmodule

// File: tb/tb_spi_responder.sv
// tb/tb_spi_responder.sv - directed and random frames against a queue-based model
module tb_spi_responder;
    localparam int H     = 8;
    localparam int DEPTH = 8;
    localparam int SYNC  = 2;

    logic clk = 1'b0;
    logic rst, sck, cs, mosi, miso, miso_oe;

    spi_responder_if bus();

    spi_responder #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC), .IDLE_BYTE(8'hFF)) dut (
        .clk         (clk),
        .Rst         (rst),
        .spi_sck     (sck),
        .spi_cs      (cs),
        .spi_mosi    (mosi),
        .spi_miso    (miso),
        .spi_miso_oe (miso_oe),
        .host        (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic       ovf_m;
    logic [7:0] mosi_buf [16];
    logic [7:0] miso_buf [16];
    logic [7:0] exp_miso [16];

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic host_push(input logic [7:0] b);
        bus.tx_din = b;
        bus.tx_wr  = 1'b1;
        wait_clk(1);
        bus.tx_wr  = 1'b0;
        if (tx_q.size() < DEPTH)
            tx_q.push_back(b);
    endtask

    // Every byte slot, including the one begun after the last complete byte, takes the TX head.
    task automatic model_frame(input int nbytes);
        for (int s = 0; s <= nbytes; s++)
            exp_miso[s] = (tx_q.size() != 0) ? tx_q.pop_front() : 8'hFF;
        for (int b = 0; b < nbytes; b++) begin
            if (rx_q.size() < DEPTH)
                rx_q.push_back(mosi_buf[b]);
            else
                ovf_m = 1'b1;
        end
    endtask

    task automatic xfer(input int nbytes, input int extra);
        int nslots;
        int nb;
        nslots = nbytes + ((extra > 0) ? 1 : 0);
        cs = 1'b0;
        wait_clk(SYNC + 2);
        check("first_bit_latency", {31'd0, miso}, {31'd0, exp_miso[0][7]});
        check("busy_in_frame", {31'd0, bus.busy}, 32'd1);
        check("oe_in_frame", {31'd0, miso_oe}, 32'd1);
        wait_clk(H - SYNC - 2);
        for (int b = 0; b < nslots; b++) begin
            nb = (b < nbytes) ? 8 : extra;
            miso_buf[b] = 8'h00;
            for (int i = 0; i < nb; i++) begin
                mosi = mosi_buf[b][7-i];
                wait_clk(H);
                miso_buf[b] = {miso_buf[b][6:0], miso};
                sck = 1'b1;
                wait_clk(H);
                sck = 1'b0;
            end
        end
        wait_clk(H);
        cs = 1'b1;
        wait_clk(8);
        for (int b = 0; b < nbytes; b++)
            check($sformatf("miso_byte%0d", b), {24'd0, miso_buf[b]}, {24'd0, exp_miso[b]});
        if (extra > 0)
            check("miso_partial", {24'd0, miso_buf[nbytes]}, {24'd0, exp_miso[nbytes] >> (8 - extra)});
        check("busy_after_frame", {31'd0, bus.busy}, 32'd0);
        check("rx_overflow", {31'd0, bus.rx_overflow}, {31'd0, ovf_m});
    endtask

    task automatic drain();
        while (rx_q.size() != 0) begin
            check("rx_avail", {31'd0, bus.rx_data_avail}, 32'd1);
            check("rx_dout", {24'd0, bus.rx_dout}, {24'd0, rx_q[0]});
            bus.rx_rd = 1'b1;
            wait_clk(1);
            bus.rx_rd = 1'b0;
            void'(rx_q.pop_front());
        end
        check("rx_empty_after_drain", {31'd0, bus.rx_data_avail}, 32'd0);
    endtask

    initial begin
        int nbytes;
        int npre;
        rst = 1'b1; cs = 1'b0; sck = 1'b0; mosi = 1'b0;
        bus.tx_din = 8'h00; bus.tx_wr = 1'b0; bus.rx_rd = 1'b0; bus.ovf_clr = 1'b0;
        ovf_m = 1'b0;
        wait_clk(4);
        check("rst_miso", {31'd0, miso}, 32'd1);
        check("rst_oe", {31'd0, miso_oe}, 32'd0);
        check("rst_tx_empty", {31'd0, bus.tx_empty}, 32'd1);
        check("rst_tx_full", {31'd0, bus.tx_full}, 32'd0);
        check("rst_avail", {31'd0, bus.rx_data_avail}, 32'd0);
        check("rst_ovf", {31'd0, bus.rx_overflow}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_rx_dout", {24'd0, bus.rx_dout}, 32'd0);
        rst = 1'b0;
        wait_clk(10);
        check("cs_low_at_release", {31'd0, bus.busy}, 32'd0);
        cs = 1'b1;
        wait_clk(8);

        mosi_buf[0] = 8'hA5;
        model_frame(1);
        xfer(1, 0);
        drain();

        host_push(8'h3C);
        host_push(8'hC3);
        mosi_buf[0] = 8'h01; mosi_buf[1] = 8'h02;
        model_frame(2);
        xfer(2, 0);
        drain();
        check("tx_empty_after_frame", {31'd0, bus.tx_empty}, 32'd1);

        mosi_buf[0] = 8'hFF;
        model_frame(0);
        xfer(0, 5);
        check("partial_not_pushed", {31'd0, bus.rx_data_avail}, 32'd0);
        host_push(8'h5A);
        mosi_buf[0] = 8'h81;
        model_frame(1);
        xfer(1, 0);
        drain();

        for (int b = 0; b < DEPTH + 1; b++)
            mosi_buf[b] = 8'($urandom);
        model_frame(DEPTH + 1);
        xfer(DEPTH + 1, 0);
        bus.ovf_clr = 1'b1;
        wait_clk(1);
        bus.ovf_clr = 1'b0;
        ovf_m = 1'b0;
        check("ovf_cleared", {31'd0, bus.rx_overflow}, 32'd0);
        drain();

        for (int b = 0; b < DEPTH + 1; b++)
            host_push(8'($urandom));
        check("tx_full", {31'd0, bus.tx_full}, 32'd1);
        check("tx_not_empty", {31'd0, bus.tx_empty}, 32'd0);
        bus.rx_rd = 1'b1;
        wait_clk(1);
        bus.rx_rd = 1'b0;
        check("rd_empty_avail", {31'd0, bus.rx_data_avail}, 32'd0);
        check("rd_empty_dout", {24'd0, bus.rx_dout}, 32'd0);
        for (int b = 0; b < DEPTH; b++)
            mosi_buf[b] = 8'($urandom);
        model_frame(DEPTH);
        xfer(DEPTH, 0);
        drain();
        check("tx_drained", {31'd0, bus.tx_empty}, 32'd1);

        host_push(8'hAA);
        cs = 1'b0;
        wait_clk(20);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        tx_q.delete();
        rx_q.delete();
        wait_clk(10);
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        check("midrst_tx_empty", {31'd0, bus.tx_empty}, 32'd1);
        cs = 1'b1;
        wait_clk(8);

        for (int f = 0; f < 5; f++) begin
            npre   = $urandom_range(0, 6);
            nbytes = $urandom_range(1, 4);
            for (int i = 0; i < npre; i++)
                host_push(8'($urandom));
            for (int b = 0; b < nbytes; b++)
                mosi_buf[b] = 8'($urandom);
            model_frame(nbytes);
            xfer(nbytes, 0);
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
